// File: rtl/timer_irq_src_pkg.sv
// Shared definitions for the machine-timer interrupt source (register map, CTRL bits, INT bus).
// Optional prescaler is built only when TIMER_PRESCALER_EN is defined.
`ifndef INT_BUS
`define INT_BUS 7:0
`endif
`ifndef INT_NONE
`define INT_NONE 8'h00
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package timer_irq_src_pkg;

   localparam logic [31:0] TIMER_CTRL  = 32'h0;
   localparam logic [31:0] TIMER_COUNT = 32'h4;
   localparam logic [31:0] TIMER_VALUE = 32'h8;

   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_IE        = 1;
   localparam int unsigned CTRL_PEND      = 2;
   localparam int unsigned CTRL_PRESC_LSB = 8;

   localparam int unsigned INT_TIMER = 0;

   typedef enum logic [1:0] {
      SEL_CTRL,
      SEL_COUNT,
      SEL_VALUE,
      SEL_NONE
   } timer_sel_e;

   // Maps a word index (byte offset >> 2) onto the register it selects.
   function automatic timer_sel_e decode_sel(input logic [31:0] word_idx);
      timer_sel_e sel;
      sel = SEL_NONE;
      if (word_idx == (TIMER_CTRL >> 2))  sel = SEL_CTRL;
      if (word_idx == (TIMER_COUNT >> 2)) sel = SEL_COUNT;
      if (word_idx == (TIMER_VALUE >> 2)) sel = SEL_VALUE;
      return sel;
   endfunction

endpackage

// File: rtl/timer_irq_src_prescaler.sv
// Tick divider for the machine timer: one tick every presc+1 enabled cycles.
// Instantiated by timer_irq_src only when TIMER_PRESCALER_EN is defined.
module timer_prescaler
   import timer_irq_src_pkg::*;
#(
   parameter int unsigned PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] div;

   assign tick = en && (div == presc);

   // Divider sits at 0 while disabled so re-enabling restarts a full period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= '0;
      end else if (!en || tick) begin
         div <= '0;
      end else begin
         div <= div + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/timer_irq_src.sv
// Memory-mapped machine timer driving bit INT_TIMER of the core interrupt-flag bus.
// Define TIMER_PRESCALER_EN to build the CTRL.PRESC tick divider.
module timer_irq_src
   import timer_irq_src_pkg::*;
#(
   parameter int unsigned BASE_SEL_W = 4,
   parameter int unsigned PRESC_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      data_i,
   output logic [31:0]      data_o,
   output logic             ack_o,
   output logic [`INT_BUS]  int_flag_o
);

   logic        en;
   logic        ie;
   logic        pend;
   logic [31:0] count;
   logic [31:0] value;
   logic [31:0] rd_data;
   logic [32:0] count_inc;
   logic        tick;
   logic        hit;
   logic        hw_set;
   logic        wr_ctrl;
   logic        wr_count;
   logic        wr_value;
   timer_sel_e  sel;

   logic unused_addr;
   assign unused_addr = ^{addr_i[31:BASE_SEL_W+2], addr_i[1:0]};

   assign sel      = decode_sel(32'(addr_i[BASE_SEL_W+1:2]));
   assign wr_ctrl  = req_i && we_i && (sel == SEL_CTRL);
   assign wr_count = req_i && we_i && (sel == SEL_COUNT);
   assign wr_value = req_i && we_i && (sel == SEL_VALUE);

`ifdef TIMER_PRESCALER_EN
   logic [PRESC_W-1:0] presc;

   timer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .presc (presc),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
      end else if (wr_ctrl) begin
         presc <= data_i[CTRL_PRESC_LSB +: PRESC_W];
      end
   end
`else
   logic [PRESC_W-1:0] unused_presc;
   assign unused_presc = '0;
   assign tick         = en;
`endif

   // 33-bit compare so a COUNT near 2^32 still reaches a smaller VALUE on the next tick.
   assign count_inc = {1'b0, count} + 33'd1;
   assign hit       = (value != '0) && (count_inc >= {1'b0, value});
   assign hw_set    = tick && hit && !wr_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (wr_count) begin
         count <= data_i;
      end else if (tick) begin
         count <= hit ? '0 : count_inc[31:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (wr_value) begin
         value <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en <= 1'b0;
         ie <= 1'b0;
      end else if (wr_ctrl) begin
         en <= data_i[CTRL_EN];
         ie <= data_i[CTRL_IE];
      end
   end

   // Hardware set has priority over the write-1-to-clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= 1'b0;
      end else if (hw_set) begin
         pend <= 1'b1;
      end else if (wr_ctrl && data_i[CTRL_PEND]) begin
         pend <= 1'b0;
      end
   end

   always_comb begin
      rd_data = `ZeroWord;
      unique case (sel)
         SEL_CTRL: begin
            rd_data[CTRL_EN]   = en;
            rd_data[CTRL_IE]   = ie;
            rd_data[CTRL_PEND] = pend;
`ifdef TIMER_PRESCALER_EN
            rd_data[CTRL_PRESC_LSB +: PRESC_W] = presc;
`endif
         end
         SEL_COUNT: rd_data = count;
         SEL_VALUE: rd_data = value;
         default:   rd_data = `ZeroWord;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_o  <= 1'b0;
         data_o <= `ZeroWord;
      end else begin
         ack_o  <= req_i;
         data_o <= (req_i && !we_i) ? rd_data : `ZeroWord;
      end
   end

   always_comb begin
      int_flag_o            = `INT_NONE;
      int_flag_o[INT_TIMER] = pend && ie;
   end

endmodule

// File: tb/tb_timer_irq_src.sv
// Scoreboard bench for timer_irq_src: bus expectations queued at issue, checked on ack_o.
// Prescaler checks are compiled in when TIMER_PRESCALER_EN is defined.
module tb_timer_irq_src;
   import timer_irq_src_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        ack_o;
   logic [7:0]  int_flag_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [32:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   timer_irq_src #(
      .BASE_SEL_W (4),
      .PRESC_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .ack_o      (ack_o),
      .int_flag_o (int_flag_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      req_i  = 1'b1;
      we_i   = 1'b1;
      addr_i = a;
      data_i = d;
      exp_q.push_back({1'b0, 32'h0});
      name_q.push_back($sformatf("wr_%0h", a));
      @(negedge clk);
      req_i = 1'b0;
      we_i  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = a;
      exp_q.push_back({1'b1, e});
      name_q.push_back(name);
      @(negedge clk);
      req_i = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic chk_flag(input string name, input logic [7:0] e);
      chk(name, {24'h0, int_flag_o}, {24'h0, e});
   endtask

   // Monitor: every ack consumes one queued expectation; data_o must idle at 0 after an ack.
   logic [32:0] mon_e;
   string       mon_n;
   logic        prev_ack = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         if (ack_o) begin
            if (exp_q.size() == 0) begin
               chk("spurious_ack", 32'h1, 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_n = name_q.pop_front();
               if (mon_e[32]) chk(mon_n, data_o, mon_e[31:0]);
            end
         end else if (prev_ack) begin
            chk("data_o_idle", data_o, 32'h0);
         end
         prev_ack = ack_o;
      end else begin
         prev_ack = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] cnt_seq [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
   logic [31:0] presc_rd;

   initial begin
      rst = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Asynchronous reset mid-count with an ack in flight.
      wr(TIMER_VALUE, 32'd3);
      wr(TIMER_CTRL, 32'h3);
      idle(3);
      wr(TIMER_COUNT, 32'h55);
      chk_flag("flag_before_reset", 8'h01);
      #2 rst = 1'b0;
      #1;
      chk_flag("rst_async_flag", 8'h00);
      chk("rst_async_ack", {31'h0, ack_o}, 32'h0);
      chk("rst_async_data", data_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      rd(TIMER_CTRL, 32'h0, "ctrl_after_rst");
      rd(TIMER_COUNT, 32'h0, "count_after_rst");
      rd(TIMER_VALUE, 32'h0, "value_after_rst");
      wr(32'hC, 32'hFFFF_FFFF);
      rd(32'hC, 32'h0, "unmapped_rd");
      wr(TIMER_CTRL, 32'h0000_FF00);
`ifdef TIMER_PRESCALER_EN
      presc_rd = 32'h0000_FF00;
`else
      presc_rd = 32'h0;
`endif
      rd(TIMER_CTRL, presc_rd, "ctrl_presc_field");

      // Periodic operation with VALUE=5, W1C and set/clear race.
      do_reset();
      wr(TIMER_VALUE, 32'd5);
      wr(TIMER_CTRL, 32'h3);
      for (int i = 0; i < 6; i++) rd(TIMER_COUNT, cnt_seq[i], $sformatf("count_seq%0d", i));
      rd(TIMER_CTRL, 32'h7, "pend_first");
      chk_flag("flag_pend", 8'h01);
      wr(TIMER_CTRL, 32'h7);
      chk_flag("flag_after_w1c", 8'h00);
      rd(TIMER_COUNT, 32'd3, "count_after_w1c");
      rd(TIMER_CTRL, 32'h3, "ctrl_cleared");
      rd(TIMER_CTRL, 32'h7, "pend_second");
      idle(3);
      wr(TIMER_CTRL, 32'h7);
      rd(TIMER_CTRL, 32'h7, "w1c_race");
      chk_flag("flag_race", 8'h01);

      // IE masking.
      do_reset();
      wr(TIMER_VALUE, 32'd3);
      wr(TIMER_CTRL, 32'h1);
      idle(3);
      chk_flag("flag_masked", 8'h00);
      rd(TIMER_CTRL, 32'h5, "pend_masked");
      wr(TIMER_CTRL, 32'h3);
      chk_flag("flag_unmasked", 8'h01);

      // VALUE written below COUNT.
      do_reset();
      wr(TIMER_CTRL, 32'h1);
      idle(9);
      wr(TIMER_VALUE, 32'd4);
      rd(TIMER_COUNT, 32'd10, "count_ten");
      rd(TIMER_COUNT, 32'd0, "count_below_reload");
      rd(TIMER_CTRL, 32'h5, "pend_below");

      // VALUE=0 wrap, and COUNT write beating a tick.
      do_reset();
      wr(TIMER_COUNT, 32'hFFFF_FFFF);
      wr(TIMER_CTRL, 32'h1);
      rd(TIMER_COUNT, 32'hFFFF_FFFF, "count_max");
      rd(TIMER_COUNT, 32'h0, "count_wrap");
      rd(TIMER_CTRL, 32'h1, "no_pend_value0");
      wr(TIMER_COUNT, 32'd7);
      rd(TIMER_COUNT, 32'd7, "count_write_wins");
      rd(TIMER_COUNT, 32'd8, "count_after_write");

`ifdef TIMER_PRESCALER_EN
      // PRESC=3: tick every 4 cycles; disabling restarts the divider.
      do_reset();
      wr(TIMER_VALUE, 32'd2);
      wr(TIMER_CTRL, 32'h303);
      idle(7);
      chk_flag("presc_flag_early", 8'h00);
      idle(1);
      chk_flag("presc_flag_8", 8'h01);
      idle(2);
      wr(TIMER_CTRL, 32'h304);
      wr(TIMER_CTRL, 32'h303);
      idle(3);
      rd(TIMER_COUNT, 32'd0, "presc_restart0");
      rd(TIMER_COUNT, 32'd1, "presc_restart1");
      rd(TIMER_CTRL, 32'h303, "presc_ctrl");
`endif

      idle(2);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_irq_src.md
Name: timer_irq_src

Overview:
- Memory-mapped machine-timer peripheral. It is the source end of the core interrupt-flag interface: it drives the core's `INT_BUS interrupt-flag input, which the interrupt arbiter treats as an asynchronous timer interrupt (mcause 0x80000004).
- Sits on the peripheral bus beside RAM/UART. Software programs the period, enables the timer, and clears the pending flag in its trap handler before mret.

Parameters:
- BASE_SEL_W, 4, width of the word-offset field decoded from addr_i (addr_i[BASE_SEL_W+1:2]).
- PRESC_W, 8, prescaler width (used only with TIMER_PRESCALER_EN).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  1  bus access request, single-cycle strobe.
- we_i  in  1  1 = write, 0 = read; qualified by req_i.
- addr_i  in  32  byte address; only the word offset is decoded.
- data_i  in  32  write data.
- data_o  out  32  read data, registered.
- ack_o  out  1  one-cycle acknowledge for every request.
- int_flag_o  out  8 (`INT_BUS)  bit0 = timer interrupt, bits[7:1] tied 0; all-zero equals `INT_NONE.

Behaviour:
Register map (word offsets):
- 0x0 CTRL
  - bit0 EN.
  - bit1 IE.
  - bit2 PEND: read / write-1-to-clear.
  - bits[15:8] PRESC (with macro only).
  - All other bits read 0.
- 0x4 COUNT: read/write.
- 0x8 VALUE: read/write.
- Other offsets: reads return 0, writes are ignored, ack still given.

Bus timing:
- req_i at cycle N gives ack_o=1 at N+1.
- Read: data_o holds the register value sampled at cycle N, valid at N+1. data_o returns to 0 the cycle after ack.
- Write: takes effect at the N+1 edge.
- req_i back-to-back every cycle is legal; each request gets its own ack.

Tick and count:
- tick = EN & prescaler expired. Without the macro, tick = EN every cycle.
- On tick, if VALUE != 0 and COUNT+1 >= VALUE:
  - COUNT <= 0, PEND <= 1.
  - Period is exactly VALUE ticks.
- On tick otherwise: COUNT <= COUNT+1, 32-bit wrap-around.
- VALUE == 0: compare disabled; COUNT free-runs and wraps; PEND never set by hardware.
- VALUE written below the current COUNT: the next tick reloads COUNT to 0 and sets PEND (>= compare, no 2^32 wait).
- EN=0: COUNT and the prescaler hold. Clearing EN resets the prescaler counter to 0. PEND is unaffected.

Interrupt output:
- int_flag_o[0] = PEND & IE, driven combinationally from registers.
- The level stays asserted until software clears PEND, so the arbiter samples it once global interrupts are re-enabled.

Simultaneous events:
- Hardware set of PEND and W1C in the same cycle: set wins, PEND stays 1.
- COUNT write and tick in the same cycle: the write wins and no reload occurs.
- CTRL write with EN going 0→1: the first tick can occur the cycle after the write lands.

Reset (asynchronous, rst=0): CTRL, COUNT, VALUE, prescaler, data_o and ack_o are all 0, so int_flag_o = 0. Reset mid-access drops the pending ack.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - A PRESC_W-bit divider counts while EN=1.
  - tick asserts when divider == CTRL.PRESC, and the divider then returns to 0. Tick period is PRESC+1 cycles.
  - CTRL[15:8] is read/write.
- Undefined:
  - No divider logic is built; tick = EN.
  - CTRL[15:8] reads 0 and writes to it are ignored.

Decomposition:
- Add to the shared package/defines:
  - Register offsets TIMER_CTRL=0x0, TIMER_COUNT=0x4, TIMER_VALUE=0x8.
  - CTRL bit indices EN=0, IE=1, PEND=2, PRESC field [15:8].
  - INT_TIMER bit index 0.
- Reuse the existing `INT_BUS, `INT_NONE, `ZeroWord.
- One natural sub-module: timer_prescaler (the divider, holding tick generation), instantiated only under TIMER_PRESCALER_EN. Everything else stays in one module.

Test Plan:
- Reset: rst=0 mid-count with COUNT=0x55 → all registers 0 and int_flag_o=0 immediately (asynchronous); reading CTRL after release returns 0.
- Periodic: VALUE=5, CTRL=0x3 → PEND rises 5 ticks after enable, COUNT sequence 1,2,3,4,0; int_flag_o=0x01; next PEND set 5 ticks later.
- W1C race: arrange CTRL write 0x7 (W1C) on the same cycle PEND is set → PEND reads 1. Plain W1C at a non-match cycle → PEND=0, int_flag_o=0x00.
- IE masking: CTRL=0x1 with VALUE=3 → PEND=1 read back but int_flag_o stays 0x00. Then write IE=1 (CTRL=0x3) → int_flag_o=0x01 the next cycle.
- VALUE below COUNT: let COUNT reach 10, write VALUE=4 → next tick COUNT=0 and PEND=1. VALUE=0 with COUNT preset 0xFFFFFFFF → tick gives COUNT=0 and PEND stays 0.
- Prescaler (macro on): PRESC=3, VALUE=2 → PEND sets 8 cycles after EN. Clear EN mid-period, re-enable → full 4-cycle spacing restarts. With macro off, CTRL[15:8] reads 0.
